uart_word_loader: RTL and testbench



---
 rtl/uart_loader_pkg.sv | 15 +
 rtl/uart_word_loader_byte_packer.sv | 34 +++
 rtl/uart_word_loader.sv | 132 +++++++++++++
 tb/tb_uart_word_loader.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART word loader.
// Provides the loader state encoding, default sync byte and word width in bytes.
package uart_loader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LEN  = 2'd1,
        DATA = 2'd2,
        CHK  = 2'd3
    } loader_state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int         WORD_BYTES        = 4;

endpackage

// File: rtl/uart_word_loader_byte_packer.sv
// Four-lane little-endian byte packer with lane counter.
// Ports: clk, rst (sync, active-high), clr (restart at lane 0), byte_in/byte_valid
// (byte strobe), word (packed {b3,b2,b1,b0}), word_valid (high with the 4th byte).
module byte_packer
    import uart_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  lane;
    // Holds the three earlier bytes; the 4th byte is merged combinationally
    // so the top can register the full word in the same cycle it arrives.
    logic [23:0] sr;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            lane <= '0;
            sr   <= '0;
        end else if (byte_valid) begin
            lane <= lane + 2'd1;
            sr   <= {byte_in, sr[23:8]};
        end
    end

    assign word       = {byte_in, sr};
    assign word_valid = byte_valid && (lane == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/uart_word_loader.sv
// Framed byte-to-word loader: sync byte, word count, payload packed into RAM writes.
// Ports: clk, rst (sync, active-high), rx_data/rx_valid (byte strobe in),
// wren/wraddr/wrdata (registered RAM write port), busy, done (pulse), err (level).
// Optional build macro LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module uart_word_loader
    import uart_loader_pkg::*;
#(
    parameter logic [7:0]        SYNC_BYTE = SYNC_BYTE_DEFAULT,
    parameter int                ADDR_W    = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              wren,
    output logic [ADDR_W-1:0] wraddr,
    output logic [31:0]       wrdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    loader_state_t     state;
    logic [8:0]        wcnt;
    logic [ADDR_W-1:0] addr;
    // Pulses with done/err so busy covers the final cycle of a frame.
    logic              fin;

    logic        sync_hit;
    logic        pk_valid;
    logic [31:0] pk_word;
    logic        pk_wvalid;

    assign sync_hit = (state == IDLE) && rx_valid && (rx_data == SYNC_BYTE);
    assign pk_valid = (state == DATA) && rx_valid;

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr        (sync_hit),
        .byte_in    (rx_data),
        .byte_valid (pk_valid),
        .word       (pk_word),
        .word_valid (pk_wvalid)
    );

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] xacc;
    logic       err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            xacc  <= '0;
            err_q <= 1'b0;
        end else if (sync_hit) begin
            xacc  <= '0;
            err_q <= 1'b0;
        end else if (pk_valid) begin
            xacc <= xacc ^ rx_data;
        end else if (state == CHK && rx_valid && rx_data != xacc) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            wcnt   <= '0;
            addr   <= '0;
            wren   <= 1'b0;
            wraddr <= '0;
            wrdata <= '0;
            done   <= 1'b0;
            fin    <= 1'b0;
        end else begin
            wren <= 1'b0;
            done <= 1'b0;
            fin  <= 1'b0;
            case (state)
                IDLE: begin
                    if (sync_hit)
                        state <= LEN;
                end
                LEN: begin
                    if (rx_valid) begin
                        // A count byte of zero encodes the maximum of 256 words.
                        wcnt  <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
                        addr  <= BASE_ADDR;
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (pk_wvalid) begin
                        wren   <= 1'b1;
                        wraddr <= addr;
                        wrdata <= pk_word;
                        addr   <= addr + ADDR_W'(WORD_BYTES);
                        wcnt   <= wcnt - 9'd1;
                        if (wcnt == 9'd1) begin
`ifdef LOADER_CHECKSUM_EN
                            state <= CHK;
`else
                            state <= IDLE;
                            done  <= 1'b1;
                            fin   <= 1'b1;
`endif
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                CHK: begin
                    if (rx_valid) begin
                        state <= IDLE;
                        fin   <= 1'b1;
                        done  <= (rx_data == xacc);
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE) || fin;

endmodule

// File: tb/tb_uart_word_loader.sv
// Randomized scoreboard bench for uart_word_loader.
// Expected writes are queued per frame; a monitor checks each wren against them.
module tb_uart_word_loader;
    import uart_loader_pkg::*;

`ifdef LOADER_CHECKSUM_EN
    localparam bit CHK_MODE = 1'b1;
`else
    localparam bit CHK_MODE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        wren;
    logic [9:0]  wraddr;
    logic [31:0] wrdata;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          addr;
        logic [31:0] data;
        bit          last;
    } wr_t;

    wr_t expq[$];
    logic prev_wren = 1'b0;

    uart_word_loader dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .wren     (wren),
        .wraddr   (wraddr),
        .wrdata   (wrdata),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares every write against the scoreboard queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (wren) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_wren: addr %0h data %0h", wraddr, wrdata);
                end else begin
                    wr_t e;
                    e = expq.pop_front();
                    check("wraddr", 64'(wraddr), 64'(e.addr));
                    check("wrdata", 64'(wrdata), 64'(e.data));
                    check("done_at_wren", 64'(done), 64'(e.last && !CHK_MODE));
                    check("busy_at_wren", 64'(busy), 64'd1);
                end
                check("no_back_to_back_wren", 64'(prev_wren), 64'd0);
            end else if (done && !CHK_MODE) begin
                checks++;
                errors++;
                $display("FAIL done_without_wren: got 1 expected 0");
            end
        end
        prev_wren <= wren;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_data  = $urandom_range(0, 255);
        repeat (gap) tick();
    endtask

    task automatic send_garbage(input int n);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'hA5) b = 8'h00;
            send_byte(b, $urandom_range(0, 2));
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_wren"}, 64'(wren), 64'd0);
        check({tag, "_wraddr"}, 64'(wraddr), 64'd0);
        check({tag, "_wrdata"}, 64'(wrdata), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_err"}, 64'(err), 64'd0);
    endtask

    // Reference: word i of a frame goes to byte address 4*i mod 1024,
    // built from payload bytes 4i..4i+3 with the first byte lowest.
    task automatic send_frame(input logic [7:0] n, input logic [7:0] p[$],
                              input int gap, input bit bad);
        int         words;
        logic [7:0] xr;
        wr_t        e;
        words = (n == 8'd0) ? 256 : int'(n);
        xr    = 8'h00;
        for (int i = 0; i < words; i++) begin
            e.addr = (4 * i) % 1024;
            e.data = {p[4*i+3], p[4*i+2], p[4*i+1], p[4*i]};
            e.last = (i == words - 1);
            expq.push_back(e);
        end
        foreach (p[j]) xr = xr ^ p[j];
        send_byte(8'hA5, gap);
        send_byte(n, gap);
        check("busy_after_len", 64'(busy), 64'd1);
        foreach (p[j]) send_byte(p[j], (CHK_MODE && j == p.size() - 1) ? 0 : gap);
        if (CHK_MODE) begin
            send_byte(xr ^ 8'(bad), 0);
            check("chk_done", 64'(done), 64'(!bad));
            check("chk_err", 64'(err), 64'(bad));
            check("chk_busy_final", 64'(busy), 64'd1);
        end
        repeat (3) tick();
        check("writes_outstanding", 64'(expq.size()), 64'd0);
        check("busy_after_frame", 64'(busy), 64'd0);
        check("err_after_frame", 64'(err), 64'(CHK_MODE && bad));
    endtask

    function automatic void rand_payload(input int words, output logic [7:0] p[$]);
        p = {};
        for (int i = 0; i < 4 * words; i++) p.push_back(8'($urandom_range(0, 255)));
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] p[$];
        logic [7:0] n;

        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) tick();
        check_idle_outputs("reset");
        rst = 1'b0;
        tick();

        // Single word, back-to-back bytes.
        p = {8'h11, 8'h22, 8'h33, 8'h44};
        send_frame(8'd1, p, 0, 1'b0);

        // Three words with 5-cycle gaps.
        rand_payload(3, p);
        send_frame(8'd3, p, 5, 1'b0);

        // Garbage ahead of the sync byte is ignored.
        send_byte(8'h00, 0);
        send_byte(8'hFF, 0);
        send_byte(8'h5A, 0);
        check("garbage_busy", 64'(busy), 64'd0);
        p = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send_frame(8'd1, p, 0, 1'b0);

        // Count byte 0 means 256 words, covering the whole address space.
        rand_payload(256, p);
        send_frame(8'd0, p, 0, 1'b0);

        // Reset in the middle of a partial word discards it.
        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        send_byte(8'h03, 0);
        rst = 1'b1;
        tick();
        check_idle_outputs("midrst");
        rst = 1'b0;
        tick();
        rand_payload(1, p);
        send_frame(8'd1, p, 0, 1'b0);

`ifdef LOADER_CHECKSUM_EN
        p = {8'h01, 8'h02, 8'h04, 8'h08};
        send_frame(8'd1, p, 0, 1'b0);
        send_frame(8'd1, p, 0, 1'b1);
        send_byte(8'hA5, 0);
        check("err_clear_on_sync", 64'(err), 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
`endif

        // Randomized frames with leading garbage and random gaps.
        for (int f = 0; f < 12; f++) begin
            send_garbage($urandom_range(0, 3));
            n = 8'($urandom_range(1, 6));
            rand_payload(int'(n), p);
            send_frame(n, p, $urandom_range(0, 3), CHK_MODE && ($urandom_range(0, 3) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
